// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions.
//   XLEN          : datapath/address width
//   NOP_INSTR     : canonical bubble encoding (addi x0, x0, 0)
//   fetch_state_t : fetch-stage controller states
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH,
    HELD,
    DRAIN
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
//   clk, reset  : clock, synchronous active-high reset
//   en          : load enable (low holds every field)
//   clr         : force a bubble (higher priority than en)
//   instrIn/pcIn/pcPlus4In/validIn : candidate contents from fetch
//   instrOut/pcOut/pcPlus4Out/validOut : registered decode-stage view
// A bubble writes NOP with valid low and leaves both PC fields untouched.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            clr,
  input  logic [XLEN-1:0] instrIn,
  input  logic [XLEN-1:0] pcIn,
  input  logic [XLEN-1:0] pcPlus4In,
  input  logic            validIn,
  output logic [XLEN-1:0] instrOut,
  output logic [XLEN-1:0] pcOut,
  output logic [XLEN-1:0] pcPlus4Out,
  output logic            validOut
);

  localparam logic [XLEN-1:0] NOP = XLEN'(NOP_INSTR);

  always_ff @(posedge clk) begin
    if (reset) begin
      instrOut   <= NOP;
      pcOut      <= '0;
      pcPlus4Out <= '0;
      validOut   <= 1'b0;
    end else if (clr) begin
      instrOut <= NOP;
      validOut <= 1'b0;
    end else if (en) begin
      if (validIn) begin
        instrOut   <= instrIn;
        pcOut      <= pcIn;
        pcPlus4Out <= pcPlus4In;
        validOut   <= 1'b1;
      end else begin
        instrOut <= NOP;
        validOut <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, single-outstanding imem port,
// one-entry hold buffer, redirect handling and the IF/ID register.
//   clk, reset            : clock, synchronous active-high reset
//   StallF/StallD/FlushD  : hazard-unit controls
//   PCSrcE/PCTargetE      : execute-stage redirect
//   imem_req/imem_addr    : fetch request (address word aligned)
//   imem_ready/imem_rdata : accept strobe, data valid in the same cycle
//   PCF                   : current fetch PC
//   InstrD/PCD/PCPlus4D/ValidD : IF/ID contents
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  fetch_state_t    state, stateNext;
  logic [XLEN-1:0] pcF, pcFNext, pcPlus4, target;
  logic [XLEN-1:0] holdInstr, holdNext;
  logic [XLEN-1:0] redirPc, redirNext;
  logic [XLEN-1:0] loadInstr;
  logic            loadValid;

  assign target  = PCTargetE & ALIGN_MASK;
  assign pcPlus4 = pcF + XLEN'(4);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      pcF       <= RESET_PC;
      holdInstr <= '0;
      redirPc   <= '0;
    end else begin
      state     <= stateNext;
      pcF       <= pcFNext;
      holdInstr <= holdNext;
      redirPc   <= redirNext;
    end
  end

  // Redirect beats StallF everywhere. A redirect that cannot complete because
  // the request is still outstanding parks its target in redirPc (DRAIN) so
  // the in-flight response is consumed before the new address is issued.
  always_comb begin
    stateNext = state;
    pcFNext   = pcF;
    holdNext  = holdInstr;
    redirNext = redirPc;
    loadInstr = imem_rdata;
    loadValid = 1'b0;
    case (state)
      FETCH: begin
        if (PCSrcE) begin
          if (imem_ready) begin
            pcFNext = target;
          end else begin
            redirNext = target;
            stateNext = DRAIN;
          end
        end else if (imem_ready) begin
          if (StallF) begin
            holdNext  = imem_rdata;
            stateNext = HELD;
          end else begin
            loadValid = 1'b1;
            pcFNext   = pcPlus4;
          end
        end
      end
      HELD: begin
        loadInstr = holdInstr;
        if (PCSrcE) begin
          pcFNext   = target;
          stateNext = FETCH;
        end else if (!StallF) begin
          loadValid = 1'b1;
          pcFNext   = pcPlus4;
          stateNext = FETCH;
        end
      end
      DRAIN: begin
        // A redirect coinciding with the draining response is the newest one.
        if (imem_ready) begin
          pcFNext   = PCSrcE ? target : redirPc;
          stateNext = FETCH;
        end else if (PCSrcE) begin
          redirNext = target;
        end
      end
      default: stateNext = FETCH;
    endcase
  end

  assign imem_req  = !reset && (state != HELD);
  assign imem_addr = pcF & ALIGN_MASK;
  assign PCF       = pcF;

  if_id_reg #(.XLEN(XLEN)) uIfId (
    .clk        (clk),
    .reset      (reset),
    .en         (!StallD),
    .clr        (FlushD),
    .instrIn    (loadInstr),
    .pcIn       (pcF),
    .pcPlus4In  (pcPlus4),
    .validIn    (loadValid),
    .instrOut   (InstrD),
    .pcOut      (PCD),
    .pcPlus4Out (PCPlus4D),
    .validOut   (ValidD)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vectors, a transaction-level reference
// model compared every cycle, plus hand-computed literal expectations.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset, StallF, StallD, FlushD, PCSrcE, imem_ready;
  logic [31:0] PCTargetE, imem_rdata, imem_addr, PCF, InstrD, PCD, PCPlus4D;
  logic        imem_req, ValidD;

  int nCompared = 0;
  int nMismatched = 0;
  int reqCountC = 0;

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .StallF     (StallF),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .PCF        (PCF),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD)
  );

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return 32'hA000_0000 | a;
  endfunction

  // Memory: data is a pure function of the address, returned with ready.
  assign imem_rdata = memWord(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] heldWord;
    logic [31:0] pending;
    logic [31:0] instrD;
    logic [31:0] pcD;
    logic [31:0] pc4D;
    logic        holding;
    logic        draining;
    logic        validD;
  } mstate_t;

  mstate_t m;
  logic    mKnown = 1'b0;

  // Rules: an instruction is available at F from the hold buffer or from a
  // ready response that is not being drained. A redirect discards whatever is
  // available; if the request is still outstanding the target waits for it.
  function automatic mstate_t modelNext(input mstate_t s, input logic r, rdy,
                                        sf, sd, fd, ps, input logic [31:0] tgt);
    mstate_t     n = s;
    logic        deliver = 1'b0;
    logic        haveInstr, outstanding;
    logic [31:0] word;
    logic [31:0] t = {tgt[31:2], 2'b00};
    if (r) begin
      n = '0;
      n.instrD = NOP;
      return n;
    end
    haveInstr   = s.holding || (!s.draining && rdy);
    word        = s.holding ? s.heldWord : memWord(s.pc);
    outstanding = !s.holding && !rdy;
    if (s.draining) begin
      if (rdy) begin
        n.pc = ps ? t : s.pending;
        n.draining = 1'b0;
      end else if (ps) n.pending = t;
    end else if (ps) begin
      n.holding = 1'b0;
      if (outstanding) begin
        n.draining = 1'b1;
        n.pending = t;
      end else n.pc = t;
    end else if (haveInstr) begin
      if (sf) begin
        n.holding = 1'b1;
        n.heldWord = word;
      end else begin
        deliver = 1'b1;
        n.holding = 1'b0;
        n.pc = s.pc + 32'd4;
      end
    end
    if (fd) begin
      n.instrD = NOP;
      n.validD = 1'b0;
    end else if (!sd) begin
      if (deliver) begin
        n.instrD = word;
        n.pcD    = s.pc;
        n.pc4D   = s.pc + 32'd4;
        n.validD = 1'b1;
      end else begin
        n.instrD = NOP;
        n.validD = 1'b0;
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m <= modelNext(m, reset, imem_ready, StallF, StallD, FlushD, PCSrcE, PCTargetE);
    if (reset) mKnown <= 1'b1;
    if (!reset && imem_req && imem_ready && imem_addr == 32'h0000_000C)
      reqCountC <= reqCountC + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s @%0t: got %08h expected %08h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mKnown) begin
      check("model_PCF", PCF, m.pc);
      check("model_req", 32'(imem_req), 32'(!reset && !m.holding));
      if (!reset && !m.holding) check("model_addr", imem_addr, m.pc);
      check("model_InstrD", InstrD, m.instrD);
      check("model_PCD", PCD, m.pcD);
      check("model_PCPlus4D", PCPlus4D, m.pc4D);
      check("model_ValidD", 32'(ValidD), 32'(m.validD));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input logic r, rdy, sf, sd, fd, ps, input logic [31:0] tgt);
    reset = r; imem_ready = rdy; StallF = sf; StallD = sd;
    FlushD = fd; PCSrcE = ps; PCTargetE = tgt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; imem_ready = 1'b1; StallF = 1'b0; StallD = 1'b0;
    FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;

    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    check("rst_req", 32'(imem_req), 0);
    check("rst_ValidD", 32'(ValidD), 0);
    check("rst_PCF", PCF, 32'h0);
    check("rst_InstrD", InstrD, NOP);

    // zero-wait streaming
    step(0, 1, 0, 0, 0, 0, 0);
    check("s0_InstrD", InstrD, 32'hA000_0000);
    check("s0_ValidD", 32'(ValidD), 1);
    check("s0_addr", imem_addr, 32'h4);
    step(0, 1, 0, 0, 0, 0, 0);
    check("s1_InstrD", InstrD, 32'hA000_0004);
    check("s1_addr", imem_addr, 32'h8);

    // two wait states at 0x8
    step(0, 0, 0, 0, 0, 0, 0);
    check("w0_addr", imem_addr, 32'h8);
    check("w0_InstrD", InstrD, NOP);
    check("w0_ValidD", 32'(ValidD), 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("w1_ValidD", 32'(ValidD), 0);
    check("w1_PCD", PCD, 32'h4);
    step(0, 1, 0, 0, 0, 0, 0);
    check("w2_InstrD", InstrD, 32'hA000_0008);

    // stall F and D while 0xC is accepted
    step(0, 1, 1, 1, 0, 0, 0);
    check("st0_PCF", PCF, 32'hC);
    check("st0_InstrD", InstrD, 32'hA000_0008);
    step(0, 1, 1, 1, 0, 0, 0);
    check("st1_req", 32'(imem_req), 0);
    check("st1_InstrD", InstrD, 32'hA000_0008);
    step(0, 1, 0, 0, 0, 0, 0);
    check("st2_InstrD", InstrD, 32'hA000_000C);
    check("st2_addr", imem_addr, 32'h10);
    check("st2_reqCountC", 32'(reqCountC), 1);

    // redirect with ready, flushed decode
    step(0, 1, 0, 0, 1, 1, 32'h40);
    check("rd_InstrD", InstrD, NOP);
    check("rd_ValidD", 32'(ValidD), 0);
    check("rd_addr", imem_addr, 32'h40);
    step(0, 1, 0, 0, 1, 1, 32'h21);
    check("rd_align_PCF", PCF, 32'h20);

    // redirect while 0x20 waits three cycles; second redirect overwrites
    step(0, 0, 0, 0, 1, 1, 32'h60);
    check("dr0_addr", imem_addr, 32'h20);
    check("dr0_req", 32'(imem_req), 1);
    step(0, 0, 0, 0, 0, 1, 32'h80);
    check("dr1_addr", imem_addr, 32'h20);
    step(0, 0, 0, 0, 0, 0, 0);
    check("dr2_addr", imem_addr, 32'h20);
    step(0, 1, 0, 0, 0, 0, 0);
    check("dr3_addr", imem_addr, 32'h80);
    check("dr3_ValidD", 32'(ValidD), 0);
    step(0, 1, 0, 0, 0, 0, 0);
    check("dr4_InstrD", InstrD, 32'hA000_0080);

    // redirect over StallF in HELD, then reset during DRAIN
    step(0, 1, 1, 1, 0, 0, 0);
    check("hr0_PCF", PCF, 32'h84);
    step(0, 1, 1, 1, 1, 1, 32'h100);
    check("hr1_PCF", PCF, 32'h100);
    check("hr1_ValidD", 32'(ValidD), 0);
    step(0, 0, 0, 0, 0, 1, 32'h200);
    check("hr2_PCF", PCF, 32'h100);
    step(1, 0, 0, 0, 0, 0, 0);
    check("rs_PCF", PCF, 32'h0);
    check("rs_req", 32'(imem_req), 0);
    step(0, 1, 0, 0, 0, 0, 0);
    check("rs_InstrD", InstrD, 32'hA000_0000);

    // PC wrap
    step(0, 1, 0, 0, 1, 1, 32'hFFFF_FFFC);
    check("wr_PCF", PCF, 32'hFFFF_FFFC);
    step(0, 1, 0, 0, 0, 0, 0);
    check("wr_InstrD", InstrD, 32'hFFFF_FFFC);
    check("wr_PCPlus4D", PCPlus4D, 32'h0);
    check("wr_PCF0", PCF, 32'h0);

    // mixed ready/stall/redirect pattern, checked by the model only
    for (int i = 0; i < 24; i++) begin
      logic [23:0] rdyPat, stlPat, redPat;
      rdyPat = 24'b1011_0110_1110_0101_1101_1011;
      stlPat = 24'b0000_1100_0001_1000_0110_0000;
      redPat = 24'b0100_0000_1000_0001_0000_0100;
      step(0, rdyPat[i], stlPat[i], stlPat[i], redPat[i], redPat[i], 32'h300 + 32'(i * 8));
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage RV32I pipeline, directly upstream of decode and controlled by the hazard unit's StallF/StallD/FlushD and the execute-stage redirect (PCSrcE/PCTargetE). It owns the PC register, a single-outstanding req/ready instruction-memory port with variable latency, a one-entry hold buffer, and the IF/ID pipeline register. When memory is slow it inserts bubbles. Branch and jump redirects are resolved here, including redirects that arrive while a fetch is in flight.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- XLEN, 32, address/instruction width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- StallF  in  1  hold PC / fetch (hazard unit)
- StallD  in  1  hold IF/ID register (hazard unit)
- FlushD  in  1  clear IF/ID register to bubble (hazard unit)
- PCSrcE  in  1  redirect request from execute
- PCTargetE  in  XLEN  redirect target
- imem_req  out  1  fetch request valid
- imem_addr  out  XLEN  fetch address (word aligned)
- imem_ready  in  1  memory accepts request; imem_rdata valid same cycle
- imem_rdata  in  XLEN  fetched instruction
- PCF  out  XLEN  current fetch PC
- InstrD  out  XLEN  IF/ID instruction
- PCD  out  XLEN  IF/ID PC
- PCPlus4D  out  XLEN  IF/ID PC+4
- ValidD  out  1  IF/ID holds a real instruction

## Operation
- States: FETCH, HELD, DRAIN.
- FETCH:
  - imem_req=1, imem_addr=PCF.
  - ready & !StallF & !PCSrcE: instruction goes to IF/ID (subject to D priority); PCF<=PCF+4.
  - ready & StallF & !PCSrcE: latch rdata/PCF into hold buffer; go HELD; PCF unchanged.
  - !ready & !PCSrcE: stay; IF/ID loads bubble.
- HELD:
  - imem_req=0; buffer is the F-stage instruction.
  - !StallF: buffer goes to IF/ID; PCF<=PCF+4; go FETCH.
- Redirect (PCSrcE=1) has priority over StallF in every state:
  - FETCH with ready, or HELD: discard fetched/buffered instruction; PCF<=PCTargetE; go FETCH.
  - FETCH with !ready: save PCTargetE in redirect register; go DRAIN.
- DRAIN:
  - imem_req=1 with the old address; address stays stable while req & !ready.
  - On ready: discard rdata; PCF<=redirect register; go FETCH.
  - A second PCSrcE in DRAIN overwrites the redirect register.
- IF/ID update priority: reset > FlushD (InstrD=NOP, ValidD=0) > StallD (hold all) > load (fetched instruction with ValidD=1, or bubble).
- A bubble is InstrD=32'h0000_0013, ValidD=0, PCD and PCPlus4D unchanged.
- PC arithmetic is modulo 2^XLEN: 32'hFFFF_FFFC+4 wraps to 0. imem_addr[1:0] are always 0; PCTargetE[1:0] are ignored (forced to 0).

## Timing
- Reset values: PCF=RESET_PC, state=FETCH, InstrD=NOP, PCD=0, PCPlus4D=0, ValidD=0, hold buffer invalid.
- imem_req is forced to 0 while reset=1.
- Reset mid-DRAIN or mid-HELD abandons the transaction. The memory model must also be reset.
- Zero-wait memory (ready=1 every cycle): one instruction per cycle. The instruction at address A appears on InstrD in the cycle after the cycle A was accepted.
- Each wait cycle adds one bubble.
- Redirect latency:
  - ready in the PCSrcE cycle: next cycle imem_addr=target.
  - DRAIN: imem_addr=target in the cycle after the draining ready.
- Each address is requested exactly once per accept; HELD never re-requests.

## Structure
- riscv_pkg holds XLEN, NOP_INSTR (32'h0000_0013), and the fetch_state_t enum {FETCH, HELD, DRAIN}.
- Sub-module if_id_reg: enable/clear pipeline register carrying InstrD/PCD/PCPlus4D/ValidD, with en=!StallD and clr=FlushD.
- FSM, PC, hold buffer and redirect register stay in fetch_stage.

## Test plan
- Reset 2 cycles, ready=1, memory word = 0xA000_0000|addr → imem_addr 0x0,0x4,0x8 on consecutive cycles; InstrD 0xA000_0000, 0xA000_0004 one cycle later; ValidD=0 during reset.
- Fetch at 0x8 with ready low 2 cycles → imem_addr held at 0x8; InstrD=NOP, ValidD=0 for 2 cycles; then InstrD=0xA000_0008.
- StallF=StallD=1 for 2 cycles while 0xC accepted → exactly one request for 0xC; PCF=0xC; InstrD unchanged. After release: InstrD=0xA000_000C, next imem_addr=0x10.
- PCSrcE=1, PCTargetE=0x40, FlushD=1, ready=1 → InstrD=NOP, ValidD=0; next imem_addr=0x40; PCF=0x40.
- PCSrcE=1 (target 0x80) while 0x20 waits 3 cycles → imem_addr stays 0x20 until ready. Response is dropped: no ValidD for 0x20. Next imem_addr=0x80.
- PCSrcE and StallF both high in HELD → buffer discarded, PCF=target; reset asserted in DRAIN → PCF=RESET_PC, state FETCH, imem_req=0 during reset.
